// File: rtl/control_unit.sv
// rtl/control_unit.sv - four-cycle fetch/decode/execute/writeback sequencer in front of the ALU
//
// Purpose: fetches 8-bit instructions from a synchronous program ROM, drives the
// ALU from the accumulator and the external register file, and retires results
// into the accumulator and flag register. Load, store, jump and halt are handled
// locally. Every instruction takes FETCH, DECODE, EXECUTE, WRITEBACK.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     leave IDLE and run from the current PC
//   prog_addr / prog_data     ROM address (registered) / data (one cycle later)
//   rf_addr / rf_rdata        register file index IR[3:0] / combinational read data
//   rf_we / rf_wdata          one-cycle write strobe / write data (accumulator)
//   alu_instr_code            IR[7:4] to the ALU
//   alu_acc / alu_operand     accumulator / register operand to the ALU
//   alu_result, alu_z..alu_s  ALU result and flags, sampled in WRITEBACK only
//   acc, flags                accumulator and {Z, CY, OV, P, S}
//   busy, halted              not in IDLE / stopped by HALT until next start

module control_unit #(
    parameter int PC_W  = 8,
    parameter int RF_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [PC_W-1:0]  prog_addr,
    input  logic [7:0]       prog_data,
    output logic [RF_AW-1:0] rf_addr,
    input  logic [7:0]       rf_rdata,
    output logic             rf_we,
    output logic [7:0]       rf_wdata,
    output logic [3:0]       alu_instr_code,
    output logic [7:0]       alu_acc,
    output logic [7:0]       alu_operand,
    input  logic [7:0]       alu_result,
    input  logic             alu_z,
    input  logic             alu_cy,
    input  logic             alu_ov,
    input  logic             alu_p,
    input  logic             alu_s,
    output logic [7:0]       acc,
    output logic [4:0]       flags,
    output logic             busy,
    output logic             halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_INC  = 4'hA;
    localparam logic [3:0] OP_LDA  = 4'hB;
    localparam logic [3:0] OP_STA  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // flags bit positions
    localparam int F_Z  = 4;
    localparam int F_CY = 3;
    localparam int F_OV = 2;
    localparam int F_P  = 1;
    localparam int F_S  = 0;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic [3:0]      opcode;
    logic            is_alu_op;
    logic            take_jump;
    logic [PC_W-1:0] wb_pc;

    assign opcode         = ir[7:4];
    assign rf_addr        = ir[RF_AW-1:0];
    assign alu_instr_code = opcode;
    assign alu_acc        = acc;
    assign alu_operand    = rf_rdata;

    assign is_alu_op = (opcode != OP_NOP) && (opcode <= OP_INC);

    // Jump target replaces the PC+1 taken in DECODE; it is also what the
    // following FETCH presents on prog_addr.
    always_comb begin
        take_jump = 1'b0;
        if (opcode == OP_JMP) begin
            take_jump = 1'b1;
        end else if (opcode == OP_JZ) begin
            take_jump = flags[F_Z];
        end
        wb_pc = take_jump ? PC_W'(rf_rdata) : pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            prog_addr <= '0;
            acc       <= '0;
            flags     <= '0;
            rf_we     <= 1'b0;
            rf_wdata  <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // prog_addr is loaded on entry to FETCH so that the
                        // synchronous ROM returns data during DECODE.
                        state     <= FETCH;
                        prog_addr <= pc;
                        halted    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    ir    <= prog_data;
                    pc    <= pc + 1'b1;
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    state <= WRITEBACK;
                    // Registered strobe lands exactly in the WRITEBACK cycle.
                    if (opcode == OP_STA) begin
                        rf_we    <= 1'b1;
                        rf_wdata <= acc;
                    end
                end
                WRITEBACK: begin
                    pc <= wb_pc;
                    if (is_alu_op) begin
                        acc        <= alu_result;
                        flags[F_Z] <= alu_z;
                        flags[F_P] <= alu_p;
                        flags[F_S] <= alu_s;
                        if (opcode == OP_ADD) begin
                            flags[F_CY] <= alu_cy;
                            flags[F_OV] <= alu_ov;
                        end
                    end else if (opcode == OP_LDA) begin
                        acc        <= rf_rdata;
                        flags[F_Z] <= (rf_rdata == 8'h00);
                        flags[F_P] <= ~^rf_rdata;
                        flags[F_S] <= rf_rdata[7];
                    end
                    if (opcode == OP_HALT) begin
                        halted <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        prog_addr <= wb_pc;
                        state     <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
